// File: rtl/serial_defs.sv
// Shared constants for the serial path: parity modes, TX FSM encoding and the
// default baud divisor.
package serial_defs;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 25 MHz system clock / 115200 baud
    localparam int BAUD_25M_115200 = 217;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so full and empty never alias.
// Push is ignored when full and pop is ignored when empty; rdata_o shows the head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// UART transmitter fed by a FIFO; configurable data bits, parity and stop bits.
// Write port: a byte is taken on a rising edge where IN_VALID and OUT_READY are both high.
module serial_tx_fifo
    import serial_defs::*;
#(
    parameter int CLKS_PER_BIT = BAUD_25M_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          IN_PB_RESET,
    input  logic [7:0]    IN_DATA,
    input  logic          IN_VALID,
    output logic          OUT_READY,
    input  logic          IN_CLR_OVF,
    output logic          OUT_SERIAL_TX,
    output logic          OUT_BUSY,
    output logic [CW-1:0] OUT_FIFO_COUNT,
    output logic          OUT_OVERFLOW
);

    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("serial_tx_fifo: unsupported parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q;

    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [FCW-1:0]       fifo_count;
    logic                 bit_done, head_par;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (IN_PB_RESET),
        .push_i  (IN_VALID),
        .pop_i   (fifo_pop),
        .wdata_i (IN_DATA[DATA_BITS-1:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bit_done = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign head_par = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : ^fifo_rdata;

    always_comb begin
        state_d    = state_q;
        baud_d     = bit_done ? '0 : baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    par_d    = head_par;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_rdata;
                            par_d    = head_par;
                            tx_d     = 1'b0;
                            state_d  = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge IN_PB_RESET) begin
        if (!IN_PB_RESET) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    // A rejected write sets the flag even when a clear arrives on the same edge.
    always_ff @(posedge CLK or negedge IN_PB_RESET) begin
        if (!IN_PB_RESET) begin
            ovf_q <= 1'b0;
        end else if (IN_VALID && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (IN_CLR_OVF) begin
            ovf_q <= 1'b0;
        end
    end

    assign OUT_READY      = !fifo_full;
    assign OUT_SERIAL_TX  = tx_q;
    assign OUT_BUSY       = (state_q != ST_IDLE);
    assign OUT_FIFO_COUNT = CW'(fifo_count);
    assign OUT_OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: four instances (8N1, 8E1, 8O1, 7E2) at 4 clocks per bit
// with a 4-entry FIFO; frames are decoded from the line and checked against a queue.
module tb_serial_tx_fifo;

  localparam int CPB  = 4;
  localparam int NDUT = 4;
  localparam int TMO  = 200;

  logic       clk;
  logic       rst_n;
  logic [7:0] din   [NDUT];
  logic       valid [NDUT];
  logic       clr   [NDUT];
  logic       ready [NDUT];
  logic       tx    [NDUT];
  logic       busy  [NDUT];
  logic [2:0] cnt   [NDUT];
  logic       ovf   [NDUT];

  logic [11:0] exp_q[$];
  int          len_q[$];
  int          total = 0;
  int          bad   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    serial_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (g == 3 ? 7 : 8),
      .PARITY       (g == 1 ? 1 : (g == 2 ? 2 : (g == 3 ? 1 : 0))),
      .STOP_BITS    (g == 3 ? 2 : 1),
      .FIFO_DEPTH   (4)
    ) u_dut (
      .CLK            (clk),
      .IN_PB_RESET    (rst_n),
      .IN_DATA        (din[g]),
      .IN_VALID       (valid[g]),
      .OUT_READY      (ready[g]),
      .IN_CLR_OVF     (clr[g]),
      .OUT_SERIAL_TX  (tx[g]),
      .OUT_BUSY       (busy[g]),
      .OUT_FIFO_COUNT (cnt[g]),
      .OUT_OVERFLOW   (ovf[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  // model of each instance's frame format
  function automatic int cfg_dbits(input int d);
    return (d == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return 1 + cfg_dbits(d) + ((cfg_par(d) != 0) ? 1 : 0) + cfg_stop(d);
  endfunction

  function automatic logic [11:0] make_frame(input int d, input logic [7:0] b);
    logic [11:0] f;
    logic        p;
    int          i;
    f = '0;
    p = 1'b0;
    for (int k = 0; k < cfg_dbits(d); k++) begin
      f[1+k] = b[k];
      p      = p ^ b[k];
    end
    i = 1 + cfg_dbits(d);
    if (cfg_par(d) != 0) begin
      f[i] = (cfg_par(d) == 2) ? ~p : p;
      i++;
    end
    for (int s = 0; s < cfg_stop(d); s++) f[i+s] = 1'b1;
    return f;
  endfunction

  // driver: called at a falling edge; the DUT samples valid on the next rising edge
  task automatic write_byte(input int d, input logic [7:0] b);
    if (ready[d] === 1'b1) begin
      exp_q.push_back(make_frame(d, b));
      len_q.push_back(frame_len(d));
    end
    din[d]   = b;
    valid[d] = 1'b1;
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  // line decoder: waits for a start bit, then samples every cycle of nbits bits
  task automatic recv_frame(input int d, input int nbits, output logic [11:0] bits,
                            output int wait_cyc, output int busy_cyc, output bit stable);
    bits     = '0;
    wait_cyc = 0;
    busy_cyc = 0;
    stable   = 1'b1;
    while (tx[d] !== 1'b0 && wait_cyc < TMO) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= TMO) begin
      stable = 1'b0;
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) bits[b] = tx[d];
        else if (tx[d] !== bits[b]) stable = 1'b0;
        if (busy[d] === 1'b1) busy_cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bit line_low;
    rst_n = 1'b0;
    #100;
    for (int d = 0; d < NDUT; d++) begin
      total++; if (tx[d] !== 1'b1) begin bad++; $display("FAIL reset_tx[%0d] got=%b exp=1", d, tx[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, busy[d]); end
      total++; if (cnt[d] !== 3'd0) begin bad++; $display("FAIL reset_count[%0d] got=%0d exp=0", d, cnt[d]); end
      total++; if (ovf[d] !== 1'b0) begin bad++; $display("FAIL reset_ovf[%0d] got=%b exp=0", d, ovf[d]); end
      total++; if (ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, ready[d]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    line_low = 1'b0;
    repeat (12) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (tx[d] !== 1'b1 || busy[d] !== 1'b0) line_low = 1'b1;
    end
    total++; if (line_low !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", line_low); end
  endtask

  task automatic test_8n1();
    logic [11:0] bits, exp;
    int          n, wc, bc;
    bit          st;
    write_byte(0, 8'h55);
    total++; if (tx[0] !== 1'b1) begin bad++; $display("FAIL 8n1_latency_tx got=%b exp=1", tx[0]); end
    exp = exp_q.pop_front();
    n   = len_q.pop_front();
    recv_frame(0, n, bits, wc, bc, st);
    total++; if (wc !== 1) begin bad++; $display("FAIL 8n1_start_delay got=%0d exp=1", wc); end
    total++; if (bits !== exp) begin bad++; $display("FAIL 8n1_frame got=%h exp=%h", bits, exp); end
    total++; if (bits[8:1] !== 8'h55) begin bad++; $display("FAIL 8n1_decode got=%h exp=55", bits[8:1]); end
    total++; if (!st) begin bad++; $display("FAIL 8n1_bit_width got=unstable exp=stable"); end
    total++; if (bc !== 40) begin bad++; $display("FAIL 8n1_busy_cycles got=%0d exp=40", bc); end
    total++; if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin bad++; $display("FAIL 8n1_end_idle got=busy%b/tx%b exp=busy0/tx1", busy[0], tx[0]); end
  endtask

  task automatic test_parity();
    logic [11:0] bits, exp;
    int          n, wc, bc;
    bit          st;
    for (int d = 1; d <= 2; d++) begin
      write_byte(d, 8'h07);
      exp = exp_q.pop_front();
      n   = len_q.pop_front();
      recv_frame(d, n, bits, wc, bc, st);
      total++; if (bits !== exp || !st) begin bad++; $display("FAIL parity_frame[%0d] got=%h exp=%h", d, bits, exp); end
      total++; if (bits[9] !== ((d == 1) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL parity_bit[%0d] got=%b exp=%b", d, bits[9], (d == 1)); end
      total++; if (bc !== 44) begin bad++; $display("FAIL parity_busy[%0d] got=%0d exp=44", d, bc); end
    end
  endtask

  task automatic test_fill_overflow();
    fork
      begin
        for (int i = 0; i < 5; i++) write_byte(0, 8'h41 + 8'(i));
        total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", cnt[0]); end
        total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", ready[0]); end
        total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", ovf[0]); end
        write_byte(0, 8'h46);
        total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b exp=1", ovf[0]); end
        total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL overflow_drop got=%0d exp=4", cnt[0]); end
        clr[0] = 1'b1;
        write_byte(0, 8'h47);
        clr[0] = 1'b0;
        total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL overflow_set_wins got=%b exp=1", ovf[0]); end
      end
      begin
        logic [11:0] bits, exp;
        int          n, wc, bc;
        bit          st;
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL b2b_queue_empty got=0 exp=%0d", 5 - f);
            break;
          end
          exp = exp_q.pop_front();
          n   = len_q.pop_front();
          recv_frame(0, n, bits, wc, bc, st);
          total++; if (bits !== exp || !st) begin bad++; $display("FAIL b2b_frame[%0d] got=%h exp=%h", f, bits, exp); end
          if (f > 0) begin
            total++; if (wc !== 0) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=0", f, wc); end
          end
        end
      end
    join
    total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", ovf[0]); end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", ovf[0]); end
    total++; if (cnt[0] !== 3'd0 || ready[0] !== 1'b1) begin bad++; $display("FAIL drained got=cnt%0d/rdy%b exp=cnt0/rdy1", cnt[0], ready[0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] bits, exp;
    int          n, wc, bc;
    bit          st, line_low;
    write_byte(0, 8'hA5);
    write_byte(0, 8'h11);
    write_byte(0, 8'h22);
    repeat (16) @(negedge clk);
    total++; if (tx[0] !== 1'b0 || cnt[0] !== 3'd2) begin bad++; $display("FAIL mid_frame_bit3 got=tx%b/cnt%0d exp=tx0/cnt2", tx[0], cnt[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_tx got=%b exp=1", tx[0]); end
    total++; if (cnt[0] !== 3'd0 || busy[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_state got=cnt%0d/busy%b exp=cnt0/busy0", cnt[0], busy[0]); end
    exp_q.delete();
    len_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_byte(0, 8'h3C);
    exp = exp_q.pop_front();
    n   = len_q.pop_front();
    recv_frame(0, n, bits, wc, bc, st);
    total++; if (bits !== exp || !st || wc !== 1) begin bad++; $display("FAIL after_reset_frame got=%h/wait%0d exp=%h/wait1", bits, wc, exp); end
    line_low = 1'b0;
    repeat (60) begin
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) line_low = 1'b1;
      @(negedge clk);
    end
    total++; if (line_low !== 1'b0) begin bad++; $display("FAIL after_reset_no_extra got=%b exp=0", line_low); end
  endtask

  task automatic test_7e2();
    logic [11:0] bits, exp;
    logic [7:0]  vals [2];
    int          n, wc, bc;
    bit          st;
    vals[0] = 8'hFF;
    vals[1] = 8'h80;
    for (int i = 0; i < 2; i++) begin
      write_byte(3, vals[i]);
      exp = exp_q.pop_front();
      n   = len_q.pop_front();
      recv_frame(3, n, bits, wc, bc, st);
      total++; if (bits !== exp || !st) begin bad++; $display("FAIL 7e2_frame[%0d] got=%h exp=%h", i, bits, exp); end
      total++; if (bc !== 44) begin bad++; $display("FAIL 7e2_busy[%0d] got=%0d exp=44", i, bc); end
    end
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          write_byte(0, 8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
      end
      begin
        logic [11:0] bits, exp;
        int          n, wc, bc;
        bit          st;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
          recv_frame(0, frame_len(0), bits, wc, bc, st);
          if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL rand_unexpected_frame got=%h exp=none", bits);
            break;
          end
          exp = exp_q.pop_front();
          n   = len_q.pop_front();
          total++; if (bits !== exp || !st || n !== frame_len(0)) begin bad++; $display("FAIL rand_frame[%0d] got=%h exp=%h", f, bits, exp); end
        end
      end
    join
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      din[d]   = 8'h00;
      valid[d] = 1'b0;
      clr[d]   = 1'b0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_fill_overflow();
    test_reset_mid_frame();
    test_7e2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
Parametrised, synthesizable UART transmitter with an input FIFO. It is the successor to the fixed 8N1 serial path that the GFX test suites drive on OUT_SERIAL_TX.
- Adds configurable frame format, a buffered valid/ready write port, back-to-back framing and overflow reporting.
- Sits between the test-suite/controller logic and the board serial pin.
- Must stay frame-compatible with the TerminalWriter bench monitor when configured 8N1.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200); must be >= 2.
- DATA_BITS, 8, data bits per frame, 5..8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits, 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- CW, $clog2(FIFO_DEPTH+1), width of the count output.

Ports:
- CLK  in  1  system clock.
- IN_PB_RESET  in  1  reset; asynchronous, active-low.
- IN_DATA  in  8  byte to send; bits above DATA_BITS-1 are ignored.
- IN_VALID  in  1  write request.
- OUT_READY  out  1  FIFO can accept; equals (count != FIFO_DEPTH).
- IN_CLR_OVF  in  1  synchronous clear of OUT_OVERFLOW.
- OUT_SERIAL_TX  out  1  serial line, idle high, registered.
- OUT_BUSY  out  1  high while a frame is on the line.
- OUT_FIFO_COUNT  out  CW  entries currently queued.
- OUT_OVERFLOW  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset, while IN_PB_RESET=0, asynchronous:
  - OUT_SERIAL_TX=1, OUT_BUSY=0, OUT_FIFO_COUNT=0, OUT_OVERFLOW=0, OUT_READY=1.
  - FIFO is flushed and the FSM is forced to IDLE.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- Write handshake:
  - A byte is pushed on a rising edge where IN_VALID and OUT_READY are both high.
  - IN_VALID high while full: byte dropped, OUT_OVERFLOW set on that edge.
  - OUT_READY is derived from the registered count only. A write when full is rejected even if a pop occurs on the same edge.
  - Simultaneous push and pop with count > 0 leaves the count unchanged.
- Overflow clear: IN_CLR_OVF clears OUT_OVERFLOW. If a new overflow occurs on the same edge, set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if count > 0, pop the head into the shift register, drive TX=0 and go to START. TX falls on the edge after the accepting edge, so there is one cycle of latency from an empty FIFO.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: LSB first, DATA_BITS bits, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: even = XOR of the DATA_BITS data bits; odd = its inverse. Held CLKS_PER_BIT cycles.
  - STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle, if count > 0, pop and go directly to START with no idle gap; else go to IDLE.
- OUT_BUSY is high in every state except IDLE.
- Frame length is exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on each bit boundary; the bit advances when the counter reaches CLKS_PER_BIT-1.
- FIFO pointers:
  - Width $clog2(FIFO_DEPTH); they wrap modulo FIFO_DEPTH.
  - The count is tracked separately, so full and empty are unambiguous.
- Invalid parameters (DATA_BITS outside 5..8, PARITY > 2, STOP_BITS outside 1..2) are rejected by an elaboration-time check.

Decomposition:
- Shared package/header serial_defs:
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state encodings.
  - Baud constant for 25 MHz/115200.
- One sub-module, sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count).
  - Reusable by a future serial receiver.
- The TX FSM, baud counter and shift register live in serial_tx_fifo.

Test Plan:
1. Reset checks:
   - Hold IN_PB_RESET=0 for 100 ns -> TX=1, BUSY=0, COUNT=0, OVERFLOW=0, READY=1.
   - Release reset with no writes -> TX stays 1.
2. 8N1 frame, CLKS_PER_BIT=4, write 0x55 -> TX falls 1 cycle after accept.
   - Bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; BUSY high exactly 40 cycles.
   - The TerminalWriter monitor decodes 0x55.
3. Parity:
   - PARITY=1, write 0x07 -> parity bit 1.
   - PARITY=2, same byte -> parity bit 0.
   - Frame is 11 bits in both cases.
4. Fill and overflow, FIFO_DEPTH=4: five consecutive writes 0x41..0x45 while the first frame is in progress.
   - First write is popped at once; 0x42..0x45 fill the FIFO, so READY=0 and COUNT=4.
   - Any further write is dropped and OVERFLOW=1.
   - All accepted bytes go out back-to-back: the stop-bit end is immediately followed by a start bit.
   - IN_CLR_OVF pulse -> OVERFLOW=0.
5. Reset mid-frame:
   - Assert reset during data bit 3 of 0xA5 with 2 bytes queued -> TX=1 asynchronously and COUNT=0.
   - After release, write 0x3C -> clean frame for 0x3C only.
6. 7E2 format, DATA_BITS=7, PARITY=1, STOP_BITS=2, write 0xFF:
   - IN_DATA[7] is ignored; data bits are seven 1s and the parity bit is 1.
   - Frame = 11 bits * CLKS_PER_BIT cycles.
